pack_ascan_gen: RTL and testbench



---
 rtl/pack_ascan_gen.sv | 109 ++++++++++
 tb/tb_pack_ascan_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pack_ascan_gen.sv
// pack_ascan_gen: packs IN_W-bit A-scan samples MSB-first into OUT_W-bit words with end-of-line flush.
// Define PACK_ASCAN_WCNT_EN to add the 16-bit output word counter port o_word_cnt.
//
// state | meaning
// RUN   | accepting samples, emitting each full word as it completes
// FLUSH | line ended; draining queued words, final one zero padded and marked last
module pack_ascan_gen #(
  parameter int IN_W      = 12,
  parameter int OUT_W     = 32,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sync,
  input  logic             i_eol,
  input  logic [IN_W-1:0]  i_in_data,
  input  logic             i_in_vld,
  output logic             o_in_rdy,
  output logic [OUT_W-1:0] o_out_data,
  output logic             o_out_vld,
  output logic             o_out_last,
`ifdef PACK_ASCAN_WCNT_EN
  output logic [15:0]      o_word_cnt,
`endif
  input  logic             i_out_rdy
);

  localparam int ACC_W  = OUT_W + IN_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int NBYTES = OUT_W / 8;
  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] IN_W_F  = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0] ACC_W_F = FILL_W'(ACC_W);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} mode_t;

  mode_t             mode;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sh;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic [OUT_W-1:0]  word;
  logic [OUT_W-1:0]  word_sw;
  logic              in_fire;
  logic              out_fire;

  // All handshake outputs decode from registered state only, so i_out_rdy never reaches o_in_rdy.
  always_comb begin
    o_in_rdy   = (mode == RUN) && (fill < OUT_W_F);
    o_out_vld  = (mode == RUN) ? (fill >= OUT_W_F) : (fill != '0);
    o_out_last = o_out_vld && (mode == FLUSH) && (fill <= OUT_W_F);
    in_fire    = i_in_vld && o_in_rdy;
    out_fire   = o_out_vld && i_out_rdy;
    fill_nxt   = fill;
    if (in_fire) begin
      fill_nxt = fill + IN_W_F;
    end else if (out_fire) begin
      fill_nxt = (fill > OUT_W_F) ? (fill - OUT_W_F) : '0;
    end
  end

  // Left-justifying the valid bits covers both the full-word and the zero-padded partial case.
  always_comb begin
    acc_sh  = acc << (ACC_W_F - fill);
    word    = acc_sh[ACC_W-1 -: OUT_W];
    word_sw = word;
    if (BYTE_SWAP) begin
      for (int b = 0; b < NBYTES; b++) begin
        word_sw[8*b +: 8] = word[8*(NBYTES-1-b) +: 8];
      end
    end
    o_out_data = o_out_vld ? word_sw : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      fill <= '0;
      mode <= RUN;
    end else if (i_sync) begin
      acc  <= '0;
      fill <= '0;
      mode <= RUN;
    end else begin
      if (in_fire) begin
        acc <= {acc[OUT_W-1:0], i_in_data};
      end
      fill <= fill_nxt;
      case (mode)
        RUN:     if (i_eol && (fill_nxt != '0)) mode <= FLUSH;
        FLUSH:   if (fill_nxt == '0) mode <= RUN;
        default: mode <= RUN;
      endcase
    end
  end

`ifdef PACK_ASCAN_WCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_word_cnt <= '0;
    end else if (i_sync) begin
      o_word_cnt <= '0;
    end else if (out_fire) begin
      o_word_cnt <= o_word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pack_ascan_gen.sv
// Directed bench for pack_ascan_gen: one swapped and one unswapped instance driven in lockstep.
module tb_pack_ascan_gen;

  localparam int IN_W  = 12;
  localparam int OUT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic i_sync, i_eol, i_in_vld, i_out_rdy;
  logic [IN_W-1:0] i_in_data;
  logic s_in_rdy, s_out_vld, s_out_last;
  logic n_in_rdy, n_out_vld, n_out_last;
  logic [OUT_W-1:0] s_out_data, n_out_data;
`ifdef PACK_ASCAN_WCNT_EN
  logic [15:0] s_word_cnt, n_word_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pack_ascan_gen #(.IN_W(IN_W), .OUT_W(OUT_W), .BYTE_SWAP(1'b1)) u_sw (
    .clk(clk), .rst(rst), .i_sync(i_sync), .i_eol(i_eol),
    .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(s_in_rdy),
    .o_out_data(s_out_data), .o_out_vld(s_out_vld), .o_out_last(s_out_last),
`ifdef PACK_ASCAN_WCNT_EN
    .o_word_cnt(s_word_cnt),
`endif
    .i_out_rdy(i_out_rdy)
  );

  pack_ascan_gen #(.IN_W(IN_W), .OUT_W(OUT_W), .BYTE_SWAP(1'b0)) u_ns (
    .clk(clk), .rst(rst), .i_sync(i_sync), .i_eol(i_eol),
    .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(n_in_rdy),
    .o_out_data(n_out_data), .o_out_vld(n_out_vld), .o_out_last(n_out_last),
`ifdef PACK_ASCAN_WCNT_EN
    .o_word_cnt(n_word_cnt),
`endif
    .i_out_rdy(i_out_rdy)
  );

  typedef struct packed {
    logic        sync;
    logic        eol;
    logic        vld;
    logic [11:0] data;
    logic        rdy;
    logic        e_in_rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic        e_last;
  } vec_t;

  vec_t vt [21];

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected data is the unswapped word; the swapped instance is checked against its byte reversal.
  task automatic chk_outs(input string tag, input logic e_rdy, input logic e_vld,
                          input logic [31:0] e_data, input logic e_last);
    chk({tag, " n_in_rdy"}, 32'(n_in_rdy), 32'(e_rdy));
    chk({tag, " n_vld"},    32'(n_out_vld), 32'(e_vld));
    chk({tag, " n_data"},   n_out_data, e_data);
    chk({tag, " n_last"},   32'(n_out_last), 32'(e_last));
    chk({tag, " s_in_rdy"}, 32'(s_in_rdy), 32'(e_rdy));
    chk({tag, " s_vld"},    32'(s_out_vld), 32'(e_vld));
    chk({tag, " s_data"},   s_out_data, swap32(e_data));
    chk({tag, " s_last"},   32'(s_out_last), 32'(e_last));
  endtask

  task automatic step(input logic sync, input logic eol, input logic vld,
                      input logic [11:0] data, input logic rdy);
    @(negedge clk);
    i_sync = sync; i_eol = eol; i_in_vld = vld; i_in_data = data; i_out_rdy = rdy;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // sync eol vld data rdy | in_rdy vld data last
    vt[0]  = '{1'b0, 1'b0, 1'b1, 12'h123, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 12'h456, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 12'h789, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 32'h12345678, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 32'h90000000, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 12'h001, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 12'h002, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 12'h003, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 12'h004, 1'b1, 1'b0, 1'b1, 32'h00100200, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 12'h004, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b1, 12'h005, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b1, 12'h006, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 32'h30040050, 1'b0};
    vt[15] = '{1'b0, 1'b0, 1'b1, 12'h007, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[16] = '{1'b0, 1'b1, 1'b1, 12'h008, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[17] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 32'h06007008, 1'b1};
    vt[18] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[19] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vt[20] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};

    rst = 1'b1;
    i_sync = 1'b0; i_eol = 1'b0; i_in_vld = 1'b0; i_in_data = '0; i_out_rdy = 1'b0;
    #2;
    chk_outs("reset", 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef PACK_ASCAN_WCNT_EN
    chk("reset wcnt", 32'(n_word_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step(vt[i].sync, vt[i].eol, vt[i].vld, vt[i].data, vt[i].rdy);
      chk_outs($sformatf("vec%0d", i), vt[i].e_in_rdy, vt[i].e_vld, vt[i].e_data, vt[i].e_last);
    end

    // Backpressure: full word held while downstream stalls, extra samples refused.
    step(1'b0, 1'b0, 1'b1, 12'h123, 1'b0);
    step(1'b0, 1'b0, 1'b1, 12'h456, 1'b0);
    step(1'b0, 1'b0, 1'b1, 12'h789, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 12'hFFF, 1'b0);
      chk_outs($sformatf("hold%0d", i), 1'b0, 1'b1, 32'h12345678, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    chk_outs("release", 1'b0, 1'b1, 32'h12345678, 1'b0);
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    chk_outs("after release", 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1);

    // Sync drops partial data and a same-cycle sample.
    step(1'b0, 1'b0, 1'b1, 12'h111, 1'b1);
    step(1'b0, 1'b0, 1'b1, 12'h222, 1'b1);
    step(1'b1, 1'b0, 1'b1, 12'h333, 1'b1);
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    chk_outs("after sync", 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 12'hABC, 1'b1);
    step(1'b0, 1'b0, 1'b1, 12'hDEF, 1'b1);
    step(1'b0, 1'b0, 1'b1, 12'h012, 1'b1);
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    chk_outs("post sync word", 1'b0, 1'b1, 32'hABCDEF01, 1'b0);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1);

`ifdef PACK_ASCAN_WCNT_EN
    begin
      int accepted;
      step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
      chk("wcnt after sync", 32'(n_word_cnt), 32'd0);
      accepted = 0;
      for (int c = 0; c < 100 && accepted < 14; c++) begin
        step(1'b0, 1'b0, 1'b1, 12'(c + 1), 1'b1);
        if (n_in_rdy) accepted++;
      end
      chk("wcnt feed count", 32'(accepted), 32'd14);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
      chk("wcnt n five", 32'(n_word_cnt), 32'd5);
      chk("wcnt s five", 32'(s_word_cnt), 32'd5);
      step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1);
      step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
      chk("wcnt cleared", 32'(n_word_cnt), 32'd0);
    end
`endif

    // Asynchronous reset during FLUSH with a word pending.
    step(1'b0, 1'b1, 1'b1, 12'h111, 1'b0);
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
    chk_outs("flush pending", 1'b0, 1'b1, 32'h11100000, 1'b1);
    rst = 1'b1;
    #1;
    chk_outs("async rst", 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
      chk_outs($sformatf("post rst%0d", i), 1'b1, 1'b0, 32'h0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
